// File: rtl/rc4_stream_cipher.sv
// RC4 stream cipher engine: key schedule, optional keystream drop, then
// in-place XOR of a width x height image over a read/modify/write bus.
// Latency: first read 257+DROP_N cycles after start; each word costs read wait + DATA_BYTES + write wait.
// Backpressure: READ/WRITE hold mode_o until dfb_i=1; abort_i returns to IDLE on the next edge.
//
// Ports:
//   clk, n_rst_i        clock, synchronous active-low reset
//   start_i, abort_i    start request (IDLE only), abort to IDLE (highest priority)
//   key_i               cipher key, byte k = key_i[8k+7:8k], latched at start
//   img_width_i/hight_i image size in pixel words, latched at start
//   dfb_i, rdata_i      bus transfer complete, read data
//   mode_o, wdata_o     bus op (00 idle, 01 read, 10 write), write data
//   pix_num_o           pixel word index of the current bus op
//   busy_o, done_o      not-IDLE status, one-cycle completion pulse
module rc4_stream_cipher #(
    parameter int KEY_BYTES  = 4,
    parameter int DATA_BYTES = 4,
    parameter int DROP_N     = 0
) (
    input  logic                    clk,
    input  logic                    n_rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [8*KEY_BYTES-1:0]  key_i,
    input  logic [19:0]             img_width_i,
    input  logic [19:0]             img_hight_i,
    input  logic                    dfb_i,
    input  logic [8*DATA_BYTES-1:0] rdata_i,
    output logic [1:0]              mode_o,
    output logic [8*DATA_BYTES-1:0] wdata_o,
    output logic [19:0]             pix_num_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int KW = 8 * KEY_BYTES;
    localparam int DW = 8 * DATA_BYTES;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_KSA   = 3'd2;
    localparam logic [2:0] ST_DROP  = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_GEN   = 3'd5;
    localparam logic [2:0] ST_WRITE = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    localparam logic [20:0] PIX_MAX   = 21'h100000;
    localparam logic [10:0] DROP_LAST = 11'((DROP_N > 0) ? DROP_N - 1 : 0);
    localparam logic [10:0] GEN_LAST  = 11'(DATA_BYTES - 1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [KW-1:0] key_q, key_d;
    logic [20:0]   total_q, total_d;
    logic [19:0]   pix_q, pix_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          done_q, done_d;
    logic [7:0]    s_q [256];
    logic [7:0]    s_d [256];

    // Word count from the full 40-bit product, clamped to the 20-bit index space.
    logic [39:0] area;
    logic [20:0] total_start;
    assign area        = {20'd0, img_width_i} * {20'd0, img_hight_i};
    assign total_start = (area > {19'd0, PIX_MAX}) ? PIX_MAX : area[20:0];

    // KSA step: j += S[i] + key byte; the key register rotates one byte per
    // step so its low byte is always key[i mod KEY_BYTES].
    logic [7:0]    ksa_j;
    logic [KW-1:0] key_rot;
    assign ksa_j = j_q + s_q[i_q] + key_q[7:0];

    generate
        if (KEY_BYTES > 1) begin : g_key_rot
            assign key_rot = {key_q[7:0], key_q[KW-1:8]};
        end else begin : g_key_one
            assign key_rot = key_q;
        end
    endgenerate

    // PRGA step. The output byte is read from the pre-swap array, so the two
    // swapped locations are forwarded explicitly (this also covers i'==j').
    logic [7:0] p_i, p_a, p_j, p_b, p_sum, p_ks;
    assign p_i   = i_q + 8'd1;
    assign p_a   = s_q[p_i];
    assign p_j   = j_q + p_a;
    assign p_b   = s_q[p_j];
    assign p_sum = p_a + p_b;
    assign p_ks  = (p_sum == p_i) ? p_b :
                   (p_sum == p_j) ? p_a : s_q[p_sum];

    // Word XOR: byte 0 is processed first; the word rotates right one byte per
    // step so the result lands back in natural byte order after DATA_BYTES steps.
    logic [DW-1:0] data_shift;
    generate
        if (DATA_BYTES > 1) begin : g_data_rot
            assign data_shift = {data_q[7:0] ^ p_ks, data_q[DW-1:8]};
        end else begin : g_data_one
            assign data_shift = data_q ^ p_ks;
        end
    endgenerate

    logic [20:0] pix_inc;
    logic [2:0]  sched_exit;
    assign pix_inc    = {1'b0, pix_q} + 21'd1;
    assign sched_exit = (total_q == 21'd0) ? ST_DONE : ST_READ;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        key_d   = key_q;
        total_d = total_q;
        pix_d   = pix_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        for (int n = 0; n < 256; n++) begin
            s_d[n] = s_q[n];
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    key_d   = key_i;
                    total_d = total_start;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                for (int n = 0; n < 256; n++) begin
                    s_d[n] = 8'(n);
                end
                i_d     = 8'd0;
                j_d     = 8'd0;
                state_d = ST_KSA;
            end
            ST_KSA: begin
                s_d[i_q]   = s_q[ksa_j];
                s_d[ksa_j] = s_q[i_q];
                i_d        = i_q + 8'd1;
                j_d        = ksa_j;
                key_d      = key_rot;
                if (i_q == 8'd255) begin
                    // PRGA starts from i=j=0.
                    i_d   = 8'd0;
                    j_d   = 8'd0;
                    cnt_d = 11'd0;
                    if (DROP_N > 0) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = sched_exit;
                        if (total_q != 21'd0) pix_d = 20'd0;
                    end
                end
            end
            ST_DROP: begin
                s_d[p_i] = p_b;
                s_d[p_j] = p_a;
                i_d      = p_i;
                j_d      = p_j;
                cnt_d    = cnt_q + 11'd1;
                if (cnt_q == DROP_LAST) begin
                    state_d = sched_exit;
                    if (total_q != 21'd0) pix_d = 20'd0;
                end
            end
            ST_READ: begin
                if (dfb_i) begin
                    data_d  = rdata_i;
                    cnt_d   = 11'd0;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                s_d[p_i] = p_b;
                s_d[p_j] = p_a;
                i_d      = p_i;
                j_d      = p_j;
                data_d   = data_shift;
                cnt_d    = cnt_q + 11'd1;
                if (cnt_q == GEN_LAST) begin
                    wdata_d = data_shift;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (dfb_i) begin
                    if (pix_inc < total_q) begin
                        pix_d   = pix_inc[19:0];
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // done_o is registered off the DONE state, so the pulse follows DONE by one cycle.
        done_d = (state_q == ST_DONE);

        // Abort wins over everything; bus-visible index and data are frozen.
        if (abort_i) begin
            state_d = ST_IDLE;
            pix_d   = pix_q;
            wdata_d = wdata_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst_i) begin
            state_q <= ST_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            key_q   <= '0;
            total_q <= 21'd0;
            pix_q   <= 20'd0;
            cnt_q   <= 11'd0;
            data_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            key_q   <= key_d;
            total_q <= total_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // State array is fully rewritten in INIT, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 256; n++) begin
            s_q[n] <= s_d[n];
        end
    end

    assign mode_o    = (state_q == ST_READ)  ? 2'b01 :
                       (state_q == ST_WRITE) ? 2'b10 : 2'b00;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign wdata_o   = wdata_q;
    assign pix_num_o = pix_q;

endmodule
